// File: rtl/rtc_pkg.sv
// Shared widths, limits, time record and the 24h->12h display helper for the RTC core.
package rtc_pkg;

   localparam int HOUR_W        = 5;
   localparam int MIN_W         = 6;
   localparam int SEC_W         = 6;
   localparam int HOURS_PER_DAY = 24;
   localparam int MIN_PER_HOUR  = 60;
   localparam int SEC_PER_MIN   = 60;

   typedef struct packed {
      logic [HOUR_W-1:0] hr;
      logic [MIN_W-1:0]  mn;
      logic [SEC_W-1:0]  sc;
   } rtc_time_t;

   // Midnight and noon both read as 12 on a 12-hour face.
   function automatic logic [HOUR_W-1:0] to_12h(input logic [HOUR_W-1:0] h);
      if (h == '0)
         return HOUR_W'(12);
      else if (h > HOUR_W'(12))
         return h - HOUR_W'(12);
      else
         return h;
   endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles; clr restarts the count.
module rtc_prescaler #(
   parameter int TICK_DIV = 100
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic clr,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] pc_q, pc_d;

   assign tick = ena && (pc_q == LAST);

   always_comb begin
      pc_d = pc_q;
      if (clr)
         pc_d = '0;
      else if (ena)
         pc_d = (pc_q == LAST) ? '0 : pc_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         pc_q <= '0;
      else
         pc_q <= pc_d;
   end

endmodule

// File: rtl/rtc_clock_core.sv
// Real-time clock core: 1 Hz timekeeping, 12/24h display, validated set and optional alarm.
// Alarm logic is built only when RTC_ALARM_EN is defined; otherwise alarm_out is tied low.
module rtc_clock_core
   import rtc_pkg::*;
#(
   parameter int TICK_DIV = 100
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              mode_24h,
   input  logic              set_valid,
   input  logic [HOUR_W-1:0] set_hour,
   input  logic [MIN_W-1:0]  set_min,
   input  logic [SEC_W-1:0]  set_sec,
   output logic              set_err,
   output logic [HOUR_W-1:0] hours,
   output logic [MIN_W-1:0]  minutes,
   output logic [SEC_W-1:0]  seconds,
   output logic              pm,
   output logic              sec_tick,
   output logic              day_tick,
   input  logic              alarm_set_valid,
   input  logic [HOUR_W-1:0] alarm_hour,
   input  logic [MIN_W-1:0]  alarm_min,
   input  logic              alarm_arm,
   input  logic              alarm_ack,
   output logic              alarm_out
);

   localparam logic [HOUR_W-1:0] HR_MAX = HOUR_W'(HOURS_PER_DAY - 1);
   localparam logic [MIN_W-1:0]  MN_MAX = MIN_W'(MIN_PER_HOUR - 1);
   localparam logic [SEC_W-1:0]  SC_MAX = SEC_W'(SEC_PER_MIN - 1);

   rtc_time_t time_q, time_d, adv;
   logic      sec_tick_q, sec_tick_d;
   logic      day_tick_q, day_tick_d;
   logic      set_err_q, set_err_d;
   logic      mode_q, mode_d;
   logic      tick, set_ok, wrap_day, alarm_err;

   rtc_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .clr   (set_ok),
      .tick  (tick)
   );

   assign set_ok = set_valid && (set_hour <= HR_MAX) && (set_min <= MN_MAX) && (set_sec <= SC_MAX);

   // One-second advance with carries; wrap_day flags 23:59:59 -> 00:00:00.
   always_comb begin
      adv      = time_q;
      wrap_day = 1'b0;
      if (time_q.sc == SC_MAX) begin
         adv.sc = '0;
         if (time_q.mn == MN_MAX) begin
            adv.mn = '0;
            if (time_q.hr == HR_MAX) begin
               adv.hr   = '0;
               wrap_day = 1'b1;
            end else begin
               adv.hr = time_q.hr + HOUR_W'(1);
            end
         end else begin
            adv.mn = time_q.mn + MIN_W'(1);
         end
      end else begin
         adv.sc = time_q.sc + SEC_W'(1);
      end
   end

   // A valid set overrides a coincident tick.
   always_comb begin
      time_d     = time_q;
      sec_tick_d = 1'b0;
      day_tick_d = 1'b0;
      mode_d     = mode_24h;
      set_err_d  = (set_valid && !set_ok) || alarm_err;
      if (set_ok) begin
         time_d.hr = set_hour;
         time_d.mn = set_min;
         time_d.sc = set_sec;
      end else if (tick) begin
         time_d     = adv;
         sec_tick_d = 1'b1;
         day_tick_d = wrap_day;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         time_q     <= '0;
         sec_tick_q <= 1'b0;
         day_tick_q <= 1'b0;
         set_err_q  <= 1'b0;
         mode_q     <= 1'b0;
      end else begin
         time_q     <= time_d;
         sec_tick_q <= sec_tick_d;
         day_tick_q <= day_tick_d;
         set_err_q  <= set_err_d;
         mode_q     <= mode_d;
      end
   end

`ifdef RTC_ALARM_EN
   logic [HOUR_W-1:0] alarm_hr_q, alarm_hr_d;
   logic [MIN_W-1:0]  alarm_mn_q, alarm_mn_d;
   logic              alarm_out_q, alarm_out_d;
   logic              alarm_ok, alarm_match;

   assign alarm_ok    = alarm_set_valid && (alarm_hour <= HR_MAX) && (alarm_min <= MN_MAX);
   assign alarm_err   = alarm_set_valid && !alarm_ok;
   assign alarm_match = tick && !set_ok && alarm_arm &&
                        (adv.hr == alarm_hr_q) && (adv.mn == alarm_mn_q) && (adv.sc == '0);

   always_comb begin
      alarm_hr_d  = alarm_hr_q;
      alarm_mn_d  = alarm_mn_q;
      alarm_out_d = alarm_out_q;
      if (alarm_ok) begin
         alarm_hr_d = alarm_hour;
         alarm_mn_d = alarm_min;
      end
      if (alarm_match)
         alarm_out_d = 1'b1;
      else if (alarm_ack || !alarm_arm)
         alarm_out_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alarm_hr_q  <= '0;
         alarm_mn_q  <= '0;
         alarm_out_q <= 1'b0;
      end else begin
         alarm_hr_q  <= alarm_hr_d;
         alarm_mn_q  <= alarm_mn_d;
         alarm_out_q <= alarm_out_d;
      end
   end

   assign alarm_out = alarm_out_q;
`else
   logic unused_alarm;
   assign unused_alarm = ^{alarm_set_valid, alarm_hour, alarm_min, alarm_arm, alarm_ack};
   assign alarm_err    = 1'b0;
   assign alarm_out    = 1'b0;
`endif

   assign hours    = mode_q ? time_q.hr : to_12h(time_q.hr);
   assign minutes  = time_q.mn;
   assign seconds  = time_q.sc;
   assign pm       = !mode_q && (time_q.hr >= HOUR_W'(12));
   assign sec_tick = sec_tick_q;
   assign day_tick = day_tick_q;
   assign set_err  = set_err_q;

endmodule

// File: doc/rtc_clock_core.md
# rtc_clock_core

Parametrised real-time clock core, next generation of the 12-hour seconds clock: configurable prescaler, runtime 12/24-hour display mode, validated time-set handshake and an optional alarm. It sits between the top-level pin wrapper and the system clock. It divides `clk` down to a 1 Hz tick and keeps hours/minutes/seconds in binary for the wrapper to pack onto pins.

## Interface
- `TICK_DIV`, 100 — `clk` cycles per second tick; legal range ≥1.
- `clk` in 1 — single clock.
- `rst_n` in 1 — synchronous, active-low reset.
- `ena` in 1 — count enable; 0 freezes the prescaler and the time.
- `mode_24h` in 1 — 1: 24-hour display; 0: 12-hour display.
- `set_valid` in 1 — load request for `set_hour`/`set_min`/`set_sec`.
- `set_hour` in 5, `set_min` in 6, `set_sec` in 6 — load value, always in 24-hour format.
- `set_err` out 1 — one-cycle pulse when a set is rejected.
- `hours` out 5 — displayed hour: 1–12 in 12h mode, 0–23 in 24h mode.
- `minutes` out 6, `seconds` out 6 — 0–59.
- `pm` out 1 — 12h mode: 1 when internal hour ≥12; 24h mode: always 0.
- `sec_tick` out 1 — one-cycle pulse on every seconds update caused by the prescaler.
- `day_tick` out 1 — one-cycle pulse on the 23:59:59→00:00:00 wrap.
- `alarm_set_valid` in 1; `alarm_hour` in 5 (24h); `alarm_min` in 6 — alarm load.
- `alarm_arm` in 1 — level; 0 disarms the alarm and clears `alarm_out`.
- `alarm_ack` in 1 — clears `alarm_out`.
- `alarm_out` out 1 — sticky alarm flag.

## Operation
- Internal state: `hr` 0–23, `mn` 0–59, `sc` 0–59, prescaler `pc` 0..TICK_DIV−1, alarm registers.
- Reset (`rst_n`=0 at an edge): all registers are 0, so time is 00:00:00, `pc`=0 and the alarm is 00:00. In 12h mode the outputs read 12:00:00 with `pm`=0. All pulse outputs and `alarm_out` are 0.
- Prescaler, when `ena`=1: if `pc`==TICK_DIV−1 then `pc`←0 and the time advances by one second; otherwise `pc`++. When `ena`=0, everything holds.
- Advance: `sc` wraps 59→0 and carries to `mn`. `mn` wraps 59→0 and carries to `hr`. `hr` wraps 23→0 and asserts `day_tick`.
- Display map (combinational from registers), 12h mode: `hr`=0→12; 1–11→same value; 12→12; 13–23→`hr`−12. 24h mode: `hr` passes through. `mode_24h` may change at any cycle and affects outputs only.
- Set is accepted in the same cycle when `set_hour`≤23, `set_min`≤59 and `set_sec`≤59:
  - time is loaded;
  - `pc`←0;
  - no `sec_tick` or `day_tick` is asserted that cycle.
- An invalid set pulses `set_err` on the next edge and changes no state. Set works regardless of `ena`.
- Set and tick in the same cycle: set wins and the tick is discarded.
- Reset in the middle of any operation wins over everything.

## Timing
- All outputs are registered, or are combinational from registers only. No input-to-output combinational path.
- First `sec_tick` occurs TICK_DIV enabled cycles after reset release. The time update and `sec_tick` are visible on the same edge.
- A set value is visible on outputs one cycle after `set_valid`. The next tick follows TICK_DIV enabled cycles later.
- `set_err`, `sec_tick` and `day_tick` are high for exactly one cycle.

## Configuration
- Macro: `RTC_ALARM_EN`.
- Defined:
  - `alarm_set_valid` loads the alarm hour/minute; values outside 0–23/0–59 pulse `set_err` and are ignored.
  - `alarm_out` sets on the edge where a prescaler advance produces `hr:mn:sc`==alarm:00 while `alarm_arm`=1. A set never triggers it.
  - `alarm_out` clears on `alarm_ack` or `alarm_arm`=0. If an ack and a new match occur in the same cycle, the match wins.
- Undefined: alarm ports remain present; inputs are ignored, `alarm_out` is tied 0 and there are no alarm registers.

## Structure
- Package `rtc_pkg` holds:
  - constants `HOUR_W`=5, `MIN_W`=6, `SEC_W`=6, `HOURS_PER_DAY`=24, `MIN_PER_HOUR`=60, `SEC_PER_MIN`=60;
  - typedef `rtc_time_t` (struct hr/mn/sc);
  - function `to_12h`.
- One sub-module, `rtc_prescaler`: parameter TICK_DIV, ports `clk`/`rst_n`/`ena`/`clr`/`tick`. Counter width is max(1, clog2(TICK_DIV)).

## Test plan
- TICK_DIV=4, reset, mode_24h=0 → outputs 12:00:00, `pm`=0. First `sec_tick` on the 4th enabled cycle after release, with `seconds`=1.
- Set 23:59:59, then 4 cycles → 00:00:00, `day_tick` and `sec_tick` both pulse once. 12h display shows 12:00:00 AM; set 13:05:00 → 12h display 1:05:00 `pm`=1, 24h display 13:05:00 `pm`=0.
- `ena`=0 for 20 cycles → time and `pc` frozen, no ticks. A set issued during this window still loads.
- Set 24:00:00, then set 10:60:00 → `set_err` pulses each time, time unchanged. A valid set coincident with the tick cycle → set value loaded, no `sec_tick`.
- `RTC_ALARM_EN`: alarm 07:30 armed, set 07:29:58, run 2 ticks → `alarm_out`=1 at 07:30:00. It stays high until `alarm_ack`. Set 07:30:00 directly → no alarm. Undefined macro → `alarm_out` stays 0.
- Reset asserted mid-count at 05:17:42 → next edge gives 00:00:00, `pc`=0, `alarm_out`=0.
